// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with a start/done handshake. The default build is radix-2.
// Define BOOTH_MULT_SEQ_RADIX4_EN to build the radix-4 (modified Booth) datapath instead.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E = WIDTH + 1;
`ifdef BOOTH_MULT_SEQ_RADIX4_EN
  localparam int BW   = E + (E % 2);
  localparam int AW   = E + 2;
  localparam int ITER = BW / 2;
  localparam int SH   = 2;
`else
  localparam int BW   = E;
  localparam int AW   = E + 1;
  localparam int ITER = E;
  localparam int SH   = 1;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [2*WIDTH-1:0]    product_q;
  logic [E-1:0]          a_q;
  logic [BW-1:0]         b_q;
  logic signed [AW-1:0]  acc_q;
  logic                  q_q;
  logic [CW-1:0]         cnt_q;

  logic signed [AW-1:0]     a_sx;
  logic signed [AW-1:0]     addend;
  logic signed [AW-1:0]     sum_d;
  logic signed [AW+BW-1:0]  pair_d;
  logic signed [AW+BW-1:0]  shifted_d;
  logic signed [AW-1:0]     acc_d;
  logic [BW-1:0]            b_d;
  logic                     q_d;

  always_comb begin
    a_sx   = {{(AW-E){a_q[E-1]}}, a_q};
    addend = '0;
`ifdef BOOTH_MULT_SEQ_RADIX4_EN
    case ({b_q[1:0], q_q})
      3'b001, 3'b010: addend = a_sx;
      3'b011:         addend = a_sx <<< 1;
      3'b100:         addend = -(a_sx <<< 1);
      3'b101, 3'b110: addend = -a_sx;
      default:        addend = '0;
    endcase
`else
    case ({b_q[0], q_q})
      2'b01:   addend = a_sx;
      2'b10:   addend = -a_sx;
      default: addend = '0;
    endcase
`endif
    sum_d     = acc_q + addend;
    pair_d    = {sum_d, b_q};
    // Arithmetic shift of the whole {acc, b} pair keeps the partial product's sign.
    shifted_d = pair_d >>> SH;
    acc_d     = shifted_d[AW+BW-1:BW];
    b_d       = shifted_d[BW-1:0];
    q_d       = b_q[SH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      q_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= {tc & a[WIDTH-1], a};
            b_q     <= {{(BW-WIDTH){tc & b[WIDTH-1]}}, b};
            acc_q   <= '0;
            q_q     <= 1'b0;
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          b_q   <= b_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            product_q <= shifted_d[2*WIDTH-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=4 and WIDTH=8 instances, vector table, corner sequences, random ops.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic        tc_in;
  logic [7:0]  a_in, b_in;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .tc(tc_in),
    .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy4), .done(done4), .product(prod4)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tc(tc_in),
    .a(a_in), .b(b_in), .busy(busy8), .done(done8), .product(prod8)
  );

  typedef struct {
    int          w;
    bit          t;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [17];

  function automatic int iter_of(input int w);
`ifdef BOOTH_MULT_SEQ_RADIX4_EN
    return (w + 2) / 2;
`else
    return w + 1;
`endif
  endfunction

  // Plain integer multiply of the operands interpreted per tc, truncated to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input bit t, input logic [7:0] av, input logic [7:0] bv);
    int x, y, p;
    x = int'(av) & ((1 << w) - 1);
    y = int'(bv) & ((1 << w) - 1);
    if (t && x >= (1 << (w - 1))) x = x - (1 << w);
    if (t && y >= (1 << (w - 1))) y = y - (1 << w);
    p = (x * y) & ((1 << (2 * w)) - 1);
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_op(input int w, input bit t, input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] p, output int runlen, output bit ok);
    @(negedge clk);
    tc_in = t; a_in = av; b_in = bv;
    if (w == 4) start4 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    runlen = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((w == 4) ? done4 : done8) begin ok = 1'b1; break; end
      if ((w == 4) ? busy4 : busy8) runlen++;
      a_in = 8'($urandom); b_in = 8'($urandom); tc_in = 1'($urandom);
      @(negedge clk);
    end
    p = (w == 4) ? {8'h00, prod4} : prod8;
  endtask

  initial begin
    logic [15:0] p, exp;
    int          runlen, dones, busy_after, first, cyc, w;
    bit          ok, t;
    logic [7:0]  av, bv;

    vecs[0]  = '{4, 1'b1, 8'h08, 8'h08, 16'h0040};
    vecs[1]  = '{4, 1'b1, 8'h08, 8'h07, 16'h00C8};
    vecs[2]  = '{4, 1'b0, 8'h0F, 8'h0F, 16'h00E1};
    vecs[3]  = '{4, 1'b1, 8'h07, 8'h07, 16'h0031};
    vecs[4]  = '{4, 1'b0, 8'h08, 8'h0F, 16'h0078};
    vecs[5]  = '{4, 1'b1, 8'h0F, 8'h08, 16'h0008};
    vecs[6]  = '{8, 1'b1, 8'h03, 8'h05, 16'h000F};
    vecs[7]  = '{8, 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[8]  = '{8, 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[9]  = '{8, 1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[10] = '{8, 1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[11] = '{8, 1'b1, 8'h01, 8'hFF, 16'hFFFF};
    vecs[12] = '{8, 1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[13] = '{8, 1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[14] = '{8, 1'b1, 8'h80, 8'hFF, 16'h0080};
    vecs[15] = '{8, 1'b1, 8'h07, 8'hFE, 16'hFFF2};
    vecs[16] = '{8, 1'b1, 8'h00, 8'h80, 16'h0000};

    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0; tc_in = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_done8", {31'd0, done8}, 32'd0);
    check("reset_prod8", {16'd0, prod8}, 32'd0);
    check("reset_prod4", {24'd0, prod4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy4", {31'd0, busy4}, 32'd0);

    // Table vectors, including the most-negative operand cases.
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].w, vecs[i].t, vecs[i].a, vecs[i].b, p, runlen, ok);
      $display("vec %0d w=%0d tc=%0d a=%h b=%h -> product=%h run=%0d", i, vecs[i].w, vecs[i].t,
               vecs[i].a, vecs[i].b, p, runlen);
      check("vec_done", {31'd0, ok}, 32'd1);
      check("vec_product", {16'd0, p}, {16'd0, vecs[i].exp});
      check("vec_runlen", runlen, iter_of(vecs[i].w));
      @(negedge clk);
      check("vec_done_width", {31'd0, (vecs[i].w == 4) ? done4 : done8}, 32'd0);
    end

    // start re-pulsed while busy must be ignored.
    @(negedge clk);
    tc_in = 1'b1; a_in = 8'd3; b_in = 8'd5; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; a_in = 8'd100;
    @(negedge clk); start8 = 1'b0; a_in = 8'd3;
    dones = 0; busy_after = 0; p = '0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin dones++; p = prod8; end
      else if (dones > 0 && busy8) busy_after++;
      @(negedge clk);
    end
    $display("busy_restart a=3 b=5 -> product=%h dones=%0d", p, dones);
    check("busy_start_dones", dones, 1);
    check("busy_start_product", {16'd0, p}, 32'h000F);
    check("busy_start_no_second", busy_after, 0);

    // Asynchronous reset during RUN aborts without a done pulse.
    @(negedge clk);
    tc_in = 1'b1; a_in = 8'hFF; b_in = 8'hFF; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_product", {16'd0, prod8}, 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (done8) dones++;
    end
    $display("abort a=ff b=ff -> dones=%0d", dones);
    check("abort_no_done", dones, 0);
    run_op(8, 1'b1, 8'h07, 8'hFE, p, runlen, ok);
    $display("after_abort a=07 b=fe -> product=%h", p);
    check("after_abort_product", {16'd0, p}, 32'hFFF2);

    // start held high: back-to-back operations ITER+1 cycles apart.
    @(negedge clk);
    tc_in = 1'b1; a_in = 8'd12; b_in = 8'd12; start8 = 1'b1;
    first = -1; cyc = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (first < 0) begin
          first = cyc;
          $display("b2b first -> product=%h", prod8);
          check("b2b_first_product", {16'd0, prod8}, 32'h0090);
          a_in = 8'h80; b_in = 8'h80;
        end else begin
          $display("b2b second -> product=%h gap=%0d", prod8, cyc - first);
          check("b2b_gap", cyc - first, iter_of(8) + 1);
          check("b2b_second_product", {16'd0, prod8}, 32'h4000);
          start8 = 1'b0; ok = 1'b1;
          break;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_completed", {31'd0, ok}, 32'd1);

    // Random operations against the reference multiply.
    dones = 0;
    for (int i = 0; i < 2000; i++) begin
      w  = ($urandom_range(1) == 0) ? 4 : 8;
      t  = 1'($urandom);
      av = 8'($urandom);
      bv = 8'($urandom);
      exp = ref_mul(w, t, av, bv);
      run_op(w, t, av, bv, p, runlen, ok);
      check("rand_done", {31'd0, ok}, 32'd1);
      check("rand_product", {16'd0, p}, {16'd0, exp});
      check("rand_runlen", runlen, iter_of(w));
      dones++;
    end
    $display("random ops completed: %0d", dones);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
